// File: rtl/etype_stamper.sv
// etype_stamper
//   Egress EtherType stamper on a per-VM transmit AXI stream, placed ahead of
//   the MAC. For each frame it rewrites the EtherType field with the value
//   configured for the frame's tid. The field is bytes 12-13, or 16-17 when
//   the frame is VLAN-tagged. Frames that end before the field is complete
//   are flagged as short. There is one register stage with full backpressure.
//
// Ports
//   aclk, aresetn       clock; asynchronous active-low reset
//   axis_in_*           input stream. tuser[0] = VLAN-tagged, sampled on beat 0
//   axis_out_*          registered output stream. tuser[0] = stamped,
//                       tuser[1] = short frame (both only on the tlast beat)
//   etype_config_sel    config table index, combinationally = axis_in_tid
//   etype_config_regs   {enable, etype[15:0]} returned for etype_config_sel
module etype_stamper #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int AXIS_ID_WIDTH     = 4,
  parameter int AXIS_DEST_WIDTH   = 0,
  parameter int MAX_PACKET_LENGTH = 1522,
  localparam int NUM_BUS_BYTES    = AXIS_BUS_WIDTH / 8,
  localparam int EFF_ID           = (AXIS_ID_WIDTH > 0) ? AXIS_ID_WIDTH : 1,
  localparam int EFF_DEST         = (AXIS_DEST_WIDTH > 0) ? AXIS_DEST_WIDTH : 1
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [AXIS_BUS_WIDTH-1:0] axis_in_tdata,
  input  logic                      axis_in_tuser,
  input  logic [EFF_ID-1:0]         axis_in_tid,
  input  logic [EFF_DEST-1:0]       axis_in_tdest,
  input  logic [NUM_BUS_BYTES-1:0]  axis_in_tkeep,
  input  logic                      axis_in_tlast,
  input  logic                      axis_in_tvalid,
  output logic                      axis_in_tready,
  output logic [AXIS_BUS_WIDTH-1:0] axis_out_tdata,
  output logic [1:0]                axis_out_tuser,
  output logic [EFF_ID-1:0]         axis_out_tid,
  output logic [EFF_DEST-1:0]       axis_out_tdest,
  output logic [NUM_BUS_BYTES-1:0]  axis_out_tkeep,
  output logic                      axis_out_tlast,
  output logic                      axis_out_tvalid,
  input  logic                      axis_out_tready,
  output logic [EFF_ID-1:0]         etype_config_sel,
  input  logic [16:0]               etype_config_regs
);

  localparam int BEAT_CBITS = $clog2(MAX_PACKET_LENGTH / NUM_BUS_BYTES + 2);
  localparam int LANE_BITS  = $clog2(NUM_BUS_BYTES);

  // Field position for untagged (offset 12) and tagged (offset 16) frames.
  // Bus widths are multiples of 8 bytes, so the two bytes never straddle beats.
  localparam logic [BEAT_CBITS-1:0] TGT_BEAT_UNTAG = BEAT_CBITS'(12 / NUM_BUS_BYTES);
  localparam logic [BEAT_CBITS-1:0] TGT_BEAT_TAG   = BEAT_CBITS'(16 / NUM_BUS_BYTES);
  localparam logic [LANE_BITS-1:0]  MSB_LANE_UNTAG = LANE_BITS'(12 % NUM_BUS_BYTES);
  localparam logic [LANE_BITS-1:0]  MSB_LANE_TAG   = LANE_BITS'(16 % NUM_BUS_BYTES);

  typedef enum logic {ST_FIRST, ST_BODY} state_t;

  state_t                    state_reg, state_next;
  logic [BEAT_CBITS-1:0]     beat_cnt_reg;
  logic                      en_reg, vlan_reg;
  logic [15:0]               etype_reg;
  logic                      stamped_reg, short_reg;

  logic                      in_ready, accept, is_first;
  logic                      cur_en, cur_vlan;
  logic [15:0]               cur_etype;
  logic [BEAT_CBITS-1:0]     tgt_beat;
  logic [LANE_BITS-1:0]      msb_lane, lsb_lane;
  logic                      on_target, keep_ok, do_stamp, short_hit;
  logic                      stamped_now, short_now;
  logic [AXIS_BUS_WIDTH-1:0] stamped_data;

  assign etype_config_sel = axis_in_tid;
  assign in_ready         = !axis_out_tvalid || axis_out_tready;
  assign axis_in_tready   = in_ready;
  assign accept           = axis_in_tvalid && in_ready;
  assign is_first         = (state_reg == ST_FIRST);

  // On beat 0 the config is being latched this cycle, so use it directly.
  assign cur_en    = is_first ? etype_config_regs[16]   : en_reg;
  assign cur_etype = is_first ? etype_config_regs[15:0] : etype_reg;
  assign cur_vlan  = is_first ? axis_in_tuser           : vlan_reg;

  assign tgt_beat  = cur_vlan ? TGT_BEAT_TAG : TGT_BEAT_UNTAG;
  assign msb_lane  = cur_vlan ? MSB_LANE_TAG : MSB_LANE_UNTAG;
  assign lsb_lane  = msb_lane + 1'b1;

  // beat_cnt saturates above any target beat, so oversize frames never
  // alias back onto the stamp position.
  assign on_target = (beat_cnt_reg == tgt_beat);
  assign keep_ok   = axis_in_tkeep[msb_lane] && axis_in_tkeep[lsb_lane];
  assign do_stamp  = cur_en && on_target && keep_ok;
  assign short_hit = (axis_in_tlast && (beat_cnt_reg < tgt_beat)) || (on_target && !keep_ok);

  assign stamped_now = stamped_reg || do_stamp;
  assign short_now   = short_reg || short_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUS_BYTES; gi++) begin : g_lane
      assign stamped_data[gi*8 +: 8] =
        (do_stamp && (msb_lane == LANE_BITS'(gi))) ? cur_etype[15:8] :
        (do_stamp && (lsb_lane == LANE_BITS'(gi))) ? cur_etype[7:0]  :
                                                     axis_in_tdata[gi*8 +: 8];
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    if (accept) begin
      if (axis_in_tlast) state_next = ST_FIRST;
      else               state_next = ST_BODY;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_FIRST;
    else          state_reg <= state_next;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_cnt_reg    <= '0;
      en_reg          <= 1'b0;
      vlan_reg        <= 1'b0;
      etype_reg       <= '0;
      stamped_reg     <= 1'b0;
      short_reg       <= 1'b0;
      axis_out_tvalid <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tuser  <= '0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
      axis_out_tkeep  <= '0;
      axis_out_tlast  <= 1'b0;
    end else begin
      if (accept) begin
        if (is_first) begin
          en_reg    <= etype_config_regs[16];
          etype_reg <= etype_config_regs[15:0];
          vlan_reg  <= axis_in_tuser;
        end
        if (axis_in_tlast)           beat_cnt_reg <= '0;
        else if (beat_cnt_reg != '1) beat_cnt_reg <= beat_cnt_reg + 1'b1;
        stamped_reg <= axis_in_tlast ? 1'b0 : stamped_now;
        short_reg   <= axis_in_tlast ? 1'b0 : short_now;
      end
      if (in_ready) begin
        axis_out_tvalid <= axis_in_tvalid;
        if (axis_in_tvalid) begin
          axis_out_tdata <= stamped_data;
          axis_out_tuser <= axis_in_tlast ? {short_now, stamped_now} : 2'b00;
          axis_out_tid   <= axis_in_tid;
          axis_out_tdest <= axis_in_tdest;
          axis_out_tkeep <= axis_in_tkeep;
          axis_out_tlast <= axis_in_tlast;
        end
      end
    end
  end

endmodule
